// File: rtl/aes_pkg.sv
// Shared AES SubBytes types: 4x4 state, S-box table, scheduler FSM states
// and the tag that travels with each lane write.
package aes_pkg;

  localparam int NUM_LANES = 4;

  // State indexed [row][col], 8-bit bytes.
  typedef logic [3:0][3:0][7:0] state_t;

  // One byte per lane.
  typedef logic [NUM_LANES-1:0][7:0] lanes_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DP_RUN = 2'd1,
    KS_RUN = 2'd2,
    DONE   = 2'd3
  } fsm_e;

  // Destination of one lane beat: which output register and which column.
  typedef struct packed {
    logic       vld;
    logic       ks;
    logic [1:0] col;
  } wr_tag_t;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

endpackage

// File: rtl/sub_bytes_sched_if.sv
// Requester-side bus of the SubBytes scheduler: datapath and key-schedule
// request/response pairs plus the busy flag.
interface sub_bytes_sched_if;
  import aes_pkg::*;

  logic        dp_req;
  state_t      dp_state;
  logic        ks_req;
  logic [31:0] ks_word;
  logic        dp_done;
  state_t      dp_out;
  logic        ks_done;
  logic [31:0] ks_out;
  logic        busy;

  modport master (
    output dp_req, dp_state, ks_req, ks_word,
    input  dp_done, dp_out, ks_done, ks_out, busy
  );

  modport slave (
    input  dp_req, dp_state, ks_req, ks_word,
    output dp_done, dp_out, ks_done, ks_out, busy
  );
endinterface

// File: rtl/sbox_lane.sv
// One AES S-box lane: combinational table lookup.
module sbox_lane
  import aes_pkg::*;
(
  input  logic [7:0] din_i,
  output logic [7:0] dout_o
);
  assign dout_o = SBOX[din_i];
endmodule

// File: rtl/sub_bytes_sched.sv
// SubBytes scheduler: four shared S-box lanes arbitrated between the AES
// datapath (4 column beats) and the key schedule (1 SubWord beat).
// Build option SBOX_PIPE_EN registers the lane outputs, delaying every write
// by one cycle; DONE then holds until the last write has landed.
module sub_bytes_sched
  import aes_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  sub_bytes_sched_if.slave bus
);

  fsm_e       state_q, state_d;
  logic [1:0] beat_q, beat_d;
  logic       own_ks_q, own_ks_d;   // requester currently granted
  logic       last_ks_q, last_ks_d; // winner of the most recent contested grant
  state_t     dp_out_q;
  logic [31:0] ks_out_q;

  lanes_t     lane_in, lane_out, res;
  wr_tag_t    tag, wr;
  logic       grant_ks, dp_done, ks_done;

  for (genvar r = 0; r < NUM_LANES; r++) begin : g_lane
    sbox_lane u_lane (.din_i(lane_in[r]), .dout_o(lane_out[r]));
  end

`ifdef SBOX_PIPE_EN
  wr_tag_t wr_q;
  lanes_t  res_q;
  // One register stage after the lanes; the tag follows its data.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= '0;
      res_q <= '0;
    end else begin
      wr_q  <= tag;
      res_q <= lane_out;
    end
  end
  assign wr  = wr_q;
  assign res = res_q;
`else
  assign wr  = tag;
  assign res = lane_out;
`endif

  // State, beat counter and arbitration history.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      beat_q    <= 2'd0;
      own_ks_q  <= 1'b0;
      last_ks_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      beat_q    <= beat_d;
      own_ks_q  <= own_ks_d;
      last_ks_q <= last_ks_d;
    end
  end

  // Next state, lane feed, write tag and done pulses.
  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    own_ks_d  = own_ks_q;
    last_ks_d = last_ks_q;
    lane_in   = '0;
    tag       = '0;
    grant_ks  = 1'b0;
    dp_done   = 1'b0;
    ks_done   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.dp_req || bus.ks_req) begin
          // On a tie the requester that lost the last tie wins.
          grant_ks = bus.ks_req && (!bus.dp_req || !last_ks_q);
          own_ks_d = grant_ks;
          if (bus.dp_req && bus.ks_req) last_ks_d = grant_ks;
          beat_d   = 2'd0;
          state_d  = grant_ks ? KS_RUN : DP_RUN;
        end
      end
      DP_RUN: begin
        for (int r = 0; r < NUM_LANES; r++) lane_in[r] = bus.dp_state[r][beat_q];
        tag    = '{vld: 1'b1, ks: 1'b0, col: beat_q};
        beat_d = beat_q + 2'd1;
        if (beat_q == 2'd3) state_d = DONE;
      end
      KS_RUN: begin
        for (int r = 0; r < NUM_LANES; r++) lane_in[r] = bus.ks_word[8*(3-r) +: 8];
        tag     = '{vld: 1'b1, ks: 1'b1, col: 2'd0};
        state_d = DONE;
      end
      DONE: begin
        // A write still in flight holds DONE for one more cycle.
        if (!wr.vld) begin
          dp_done = !own_ks_q;
          ks_done = own_ks_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Result registers; only the tagged destination is written.
  always_ff @(posedge clk) begin
    if (rst) begin
      dp_out_q <= '0;
      ks_out_q <= '0;
    end else if (wr.vld) begin
      if (wr.ks) ks_out_q <= {res[0], res[1], res[2], res[3]};
      else for (int r = 0; r < NUM_LANES; r++) dp_out_q[r][wr.col] <= res[r];
    end
  end

  assign bus.dp_done = dp_done;
  assign bus.ks_done = ks_done;
  assign bus.dp_out  = dp_out_q;
  assign bus.ks_out  = ks_out_q;
  assign bus.busy    = (state_q != IDLE);

endmodule

// File: doc/sub_bytes_sched.md
SUB_BYTES_SCHED -- requirements
Module: sub_bytes_sched

Interface
REQ-001 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1, reset that is synchronous and active-high.
REQ-003 SHALL have port dp_req, input, 1, datapath requests SubBytes of a full 4x4 state; level, held until dp_done.
REQ-004 SHALL have port dp_state, input, 4x4 array of 8-bit bytes indexed [row][col], state to substitute; stable while dp_req is high.
REQ-005 SHALL have port ks_req, input, 1, key schedule requests SubWord; level, held until ks_done.
REQ-006 SHALL have port ks_word, input, 32, word to substitute; byte 0 is bits [31:24]; stable while ks_req is high.
REQ-007 SHALL have port dp_done, output, 1, one-cycle pulse; dp_out is valid.
REQ-008 SHALL have port dp_out, output, 4x4 array of 8-bit bytes, substituted state; held until the next datapath grant.
REQ-009 SHALL have port ks_done, output, 1, one-cycle pulse; ks_out is valid.
REQ-010 SHALL have port ks_out, output, 32, substituted word; held until the next key-schedule grant.
REQ-011 SHALL have port busy, output, 1, high in any state other than IDLE.

Function
REQ-012 SHALL share exactly four S-box lanes between both requesters; no other S-box instances.
REQ-013 SHALL implement the FSM states IDLE, DP_RUN, KS_RUN and DONE.
REQ-014 From IDLE, SHALL move to DP_RUN (beat=0) or KS_RUN when a request is sampled; otherwise SHALL stay in IDLE.
REQ-015 When both requests are sampled in IDLE, SHALL grant round-robin: the requester not granted last.
REQ-016 In DP_RUN beat c (0..3), SHALL feed column dp_state[0..3][c] to lanes 0..3 and SHALL write the results to dp_out[0..3][c].
REQ-017 SHALL advance beat with a 2-bit counter; after beat 3 it SHALL move to DONE.
REQ-018 In KS_RUN, SHALL feed ks_word bytes 0..3 to lanes 0..3, SHALL write ks_out, and SHALL move to DONE.
REQ-019 In DONE, SHALL pulse the done output of the granted requester for one cycle, then SHALL return to IDLE.
REQ-020 SHALL ignore requests sampled in DONE; a requester SHALL deassert req on the edge where it samples its done.
REQ-021 Latency from the first edge sampling req high in IDLE to the done pulse (without REQ-027) SHALL be: datapath, done high in cycle k+5; key schedule, done high in cycle k+2.
REQ-022 A request arriving while busy SHALL be held pending; it is serviced at the next IDLE, with round-robin applied.
REQ-023 SHALL NOT modify the non-granted requester's output register during an operation.

Reset
REQ-024 When rst is sampled high, the FSM SHALL go to IDLE, beat SHALL be 0, and dp_done, ks_done and busy SHALL be 0.
REQ-025 When rst is sampled high, dp_out and ks_out SHALL be all zero, and last-grant SHALL be the key schedule, so the datapath wins the first tie.
REQ-026 Reset mid-operation SHALL abort it with no done pulse; the requester re-issues its request.

Configuration
REQ-027 With SBOX_PIPE_EN defined, SHALL register the lane outputs (one stage); each write lands one cycle later, so datapath latency is k+6 and key latency is k+3; DONE SHALL wait for the last write.
REQ-028 Without SBOX_PIPE_EN, lanes SHALL be purely combinational, with the latencies of REQ-021.

Structure
REQ-029 Package aes_pkg SHALL hold the state typedef (4x4 of 8-bit bytes), the 256-entry S-box constant and the FSM state enum.
REQ-030 SHALL instantiate sub-module sbox_lane (8-bit in, 8-bit out, lookup of the aes_pkg S-box) four times.

Verification
REQ-031 Scenario 1: dp_state all 8'h00 -> dp_out all 8'h63; dp_done in cycle k+5 (k+6 with SBOX_PIPE_EN).
REQ-032 Scenario 2: dp_state column 0 = 19,3d,e3,be -> dp_out column 0 = d4,27,11,ae; other columns checked against the S-box.
REQ-033 Scenario 3: ks_word 32'hcf4f3c09 -> ks_out 32'h8a84eb01; ks_done in cycle k+2.
REQ-034 Scenario 4: dp_req and ks_req rise together after reset -> datapath served first, key schedule second; repeating the tie -> key schedule first.
REQ-035 Scenario 5: rst asserted during DP_RUN beat 2 -> IDLE next cycle, dp_out zero, no dp_done; the re-issued request completes correctly.
REQ-036 Scenario 6: ks_req raised during DP_RUN -> dp_out is not disturbed; ks_done follows 3 cycles after dp_done (IDLE, KS_RUN, DONE).
